// File: rtl/celloutsig_pkg.sv
// Shared types and the per-lane cell function for the celloutsig pipeline.
// Pure combinational helpers only; no state lives here.
package celloutsig_pkg;

  localparam int LANE_W = 32;

  typedef enum logic [1:0] {
    MODE_LEGACY = 2'd0,
    MODE_PARITY = 2'd1,
    MODE_FOLD   = 2'd2,
    MODE_PASS   = 2'd3
  } mode_e;

  function automatic logic [LANE_W-1:0] lane_cell(
    input mode_e             m,
    input logic [LANE_W-1:0] w,
    input logic [LANE_W-1:0] w_prev
  );
    logic [LANE_W-1:0] r;
    r = '0;
    case (m)
      MODE_LEGACY: r[0] = (w[31:30] != 2'b00) & w[17];
      MODE_PARITY: begin
        for (int i = 0; i < 4; i++) begin
          r[i] = ^w[8*i +: 8];
        end
      end
      MODE_FOLD:   r = w | w_prev;
      default:     r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/celloutsig_stage.sv
// One pipeline register (valid + data); loads on en, holds otherwise.
// Latency 1 cycle; stalls by holding when en is low.
module celloutsig_stage #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (en) begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/celloutsig_pipe.sv
// Lane-wise cell function, STAGES-deep stallable pipeline, running signature and beat count.
// Latency STAGES cycles; whole pipe freezes while out_valid & ~out_ready.
module celloutsig_pipe
  import celloutsig_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              clear,
  output logic [DATA_W-1:0] sig,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int LANES = DATA_W / LANE_W;

  logic              adv;
  logic              hs;
  logic [DATA_W-1:0] cell_data;
  logic [STAGES:0]   stg_valid;
  logic [DATA_W-1:0] stg_data [0:STAGES];

  always_comb begin
    cell_data = '0;
    for (int k = 0; k < LANES; k++) begin
      cell_data[k*LANE_W +: LANE_W] = lane_cell(mode_e'(mode),
          in_data[k*LANE_W +: LANE_W],
          in_data[((k + LANES - 1) % LANES)*LANE_W +: LANE_W]);
    end
  end

  // Bubbles are never collapsed: one global advance keeps latency fixed at STAGES.
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv & ~rst;

  assign stg_valid[0] = in_valid;
  assign stg_data[0]  = cell_data;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    celloutsig_stage #(.W(DATA_W)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (adv),
      .d_valid (stg_valid[i]),
      .d_data  (stg_data[i]),
      .q_valid (stg_valid[i+1]),
      .q_data  (stg_data[i+1])
    );
  end

  assign out_valid = stg_valid[STAGES];
  assign out_data  = stg_data[STAGES];
  assign hs        = out_valid & out_ready;

  // clear wins over a coincident handshake; the beat still leaves the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig      <= '0;
      beat_cnt <= '0;
    end else if (clear) begin
      sig      <= '0;
      beat_cnt <= '0;
    end else if (hs) begin
      sig <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ out_data;
      if (beat_cnt != '1) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule
